// File: rtl/mem_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
// Holds the responder state encoding and the default bus widths.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int WAIT_MAX   = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, DEPTH x DATA_W, with one write enable and a registered read.
// A read during a write to the same address returns the old contents.
module ram_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder for the datapath MAR/MDR interface: wait-state counter,
// 4-phase request/ready handshake, and a registered Mdatain holding the last read.
module memory_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MARaddr,
  input  logic [DATA_W-1:0] MDRdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              mem_busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_isWrite;
  logic [DATA_W-1:0] r_mdatain;
  logic              r_ready;
  logic              r_busy;

  logic              w_commit;
  logic              w_we;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [DATA_W-1:0] w_rdData;

  // The RAM sees the live address while idle so the registered read is already
  // valid by the commit edge, even with zero wait states.
  assign w_ramAddr = (r_state == ST_IDLE) ? MARaddr : r_addr;
  assign w_commit  = (r_state == ST_ACCESS) && (r_count == '0);
  assign w_we      = w_commit && r_isWrite && clr;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_ramAddr),
    .i_wdata (r_data),
    .o_rdata (w_rdData)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_isWrite <= 1'b0;
      r_mdatain <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Read || Write) begin
            r_addr    <= MARaddr;
            r_data    <= MDRdata;
            r_isWrite <= Write;
            r_count   <= WAIT_INIT;
            r_busy    <= 1'b1;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end else begin
            if (!r_isWrite) begin
              r_mdatain <= w_rdData;
            end
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!Read && !Write) begin
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Mdatain   = r_mdatain;
  assign mem_ready = r_ready;
  assign mem_busy  = r_busy;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a WAIT_STATES=2 instance drives most scenarios,
// a WAIT_STATES=0 instance covers the minimum-latency case.
module tb_memory_responder;

  logic        clk;
  logic        clr;
  logic        Read, Write;
  logic [8:0]  MARaddr;
  logic [31:0] MDRdata;
  logic [31:0] Mdatain;
  logic        mem_ready, mem_busy;

  logic        read0, write0;
  logic [8:0]  addr0;
  logic [31:0] wdata0;
  logic [31:0] mdatain0;
  logic        ready0, busy0;

  int checks = 0;
  int errors = 0;

  memory_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .Read      (Read),
    .Write     (Write),
    .MARaddr   (MARaddr),
    .MDRdata   (MDRdata),
    .Mdatain   (Mdatain),
    .mem_ready (mem_ready),
    .mem_busy  (mem_busy)
  );

  memory_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) dut0 (
    .clk       (clk),
    .clr       (clr),
    .Read      (read0),
    .Write     (write0),
    .MARaddr   (addr0),
    .MDRdata   (wdata0),
    .Mdatain   (mdatain0),
    .mem_ready (ready0),
    .mem_busy  (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request from #1 after an edge; lat is the number of edges after
  // the accepting edge until mem_ready is seen, or -1 on timeout.
  task automatic do_access(input logic rd, input logic wr, input logic [8:0] a,
                           input logic [31:0] d, input logic scramble,
                           input logic pulse, output int lat, output logic busySeen);
    Read = rd; Write = wr; MARaddr = a; MDRdata = d;
    @(posedge clk); #1;
    busySeen = mem_busy;
    if (scramble) begin
      MARaddr = a ^ 9'h001;
      MDRdata = 32'hFFFF_FFFF;
    end
    if (pulse) begin
      Read = 1'b0; Write = 1'b0;
    end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_req();
    Read = 1'b0; Write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b0; Read = 1'b0; Write = 1'b0; MARaddr = '0; MDRdata = '0;
    read0 = 1'b0; write0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Mdatain !== 32'h0) begin errors++; $display("[TB] FAIL reset_mdatain got %h expected %h", Mdatain, 32'h0); end
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", mem_ready); end
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", mem_busy); end
    clr = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int lat; logic busySeen;
    do_access(1'b0, 1'b1, 9'h014, 32'h0000_0012, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (busySeen !== 1'b1) begin errors++; $display("[TB] FAIL write_busy got %b expected 1", busySeen); end
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL write_latency got %0d expected 3", lat); end
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL write_busy_at_ready got %b expected 0", mem_busy); end
    release_req();
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL write_ready_drop got %b expected 0", mem_ready); end
  endtask

  task automatic test_read();
    int lat; logic busySeen;
    do_access(1'b1, 1'b0, 9'h014, 32'h0, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL read_latency got %0d expected 3", lat); end
    checks++;
    if (Mdatain !== 32'h0000_0012) begin errors++; $display("[TB] FAIL read_data got %h expected %h", Mdatain, 32'h12); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL read_ready_hold got %b expected 1", mem_ready); end
    checks++;
    if (mem_busy !== 1'b0) begin errors++; $display("[TB] FAIL read_no_new_access got %b expected 0", mem_busy); end
    release_req();
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL read_ready_drop got %b expected 0", mem_ready); end
    MARaddr = 9'h000;
    @(posedge clk); #1;
    checks++;
    if (Mdatain !== 32'h0000_0012) begin errors++; $display("[TB] FAIL read_data_hold got %h expected %h", Mdatain, 32'h12); end
  endtask

  task automatic test_frozen_capture();
    int lat; logic busySeen;
    do_access(1'b0, 1'b1, 9'h001, 32'h1111_1111, 1'b0, 1'b0, lat, busySeen);
    release_req();
    do_access(1'b0, 1'b1, 9'h000, 32'h2891_8000, 1'b1, 1'b0, lat, busySeen);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL frozen_latency got %0d expected 3", lat); end
    release_req();
    do_access(1'b1, 1'b0, 9'h000, 32'h0, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (Mdatain !== 32'h2891_8000) begin errors++; $display("[TB] FAIL frozen_addr0 got %h expected %h", Mdatain, 32'h2891_8000); end
    release_req();
    do_access(1'b1, 1'b0, 9'h001, 32'h0, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (Mdatain !== 32'h1111_1111) begin errors++; $display("[TB] FAIL frozen_addr1 got %h expected %h", Mdatain, 32'h1111_1111); end
    release_req();
  endtask

  task automatic test_write_priority();
    int lat; logic busySeen;
    do_access(1'b1, 1'b1, 9'h020, 32'hA5A5_A5A5, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL prio_latency got %0d expected 3", lat); end
    checks++;
    if (Mdatain !== 32'h1111_1111) begin errors++; $display("[TB] FAIL prio_mdatain_kept got %h expected %h", Mdatain, 32'h1111_1111); end
    release_req();
    do_access(1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (Mdatain !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL prio_readback got %h expected %h", Mdatain, 32'hA5A5_A5A5); end
    release_req();
  endtask

  task automatic test_early_withdraw();
    int lat; logic busySeen;
    do_access(1'b1, 1'b0, 9'h014, 32'h0, 1'b0, 1'b1, lat, busySeen);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL pulse_latency got %0d expected 3", lat); end
    checks++;
    if (Mdatain !== 32'h0000_0012) begin errors++; $display("[TB] FAIL pulse_data got %h expected %h", Mdatain, 32'h12); end
    @(posedge clk); #1;
    checks++;
    if (mem_ready !== 1'b0) begin errors++; $display("[TB] FAIL pulse_ready_one_cycle got %b expected 0", mem_ready); end
    do_access(1'b1, 1'b0, 9'h020, 32'h0, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (lat !== 3 || Mdatain !== 32'hA5A5_A5A5) begin
      errors++; $display("[TB] FAIL back_to_back got lat %0d data %h expected lat 3 data %h", lat, Mdatain, 32'hA5A5_A5A5);
    end
    release_req();
  endtask

  task automatic test_zero_wait();
    write0 = 1'b1; addr0 = 9'h005; wdata0 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checks++;
    if (busy0 !== 1'b1 || ready0 !== 1'b0) begin
      errors++; $display("[TB] FAIL ws0_accept got busy %b ready %b expected busy 1 ready 0", busy0, ready0);
    end
    @(posedge clk); #1;
    checks++;
    if (ready0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++; $display("[TB] FAIL ws0_write_ready got ready %b busy %b expected ready 1 busy 0", ready0, busy0);
    end
    write0 = 1'b0;
    @(posedge clk); #1;
    read0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ready0 !== 1'b1 || mdatain0 !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL ws0_read got ready %b data %h expected ready 1 data %h", ready0, mdatain0, 32'hDEAD_BEEF);
    end
    read0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    int lat; logic busySeen;
    do_access(1'b0, 1'b1, 9'h030, 32'hCAFE_0030, 1'b0, 1'b0, lat, busySeen);
    release_req();
    Write = 1'b1; MARaddr = 9'h030; MDRdata = 32'h0000_0001;
    @(posedge clk); #1;
    checks++;
    if (mem_busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy got %b expected 1", mem_busy); end
    clr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_ready !== 1'b0 || mem_busy !== 1'b0 || Mdatain !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs got ready %b busy %b data %h expected 0 0 0", mem_ready, mem_busy, Mdatain);
    end
    Write = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 9'h030, 32'h0, 1'b0, 1'b0, lat, busySeen);
    checks++;
    if (lat !== 3) begin errors++; $display("[TB] FAIL rst_mid_read_latency got %0d expected 3", lat); end
    checks++;
    if (Mdatain !== 32'hCAFE_0030) begin errors++; $display("[TB] FAIL rst_mid_ram_kept got %h expected %h", Mdatain, 32'hCAFE_0030); end
    release_req();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_frozen_capture();
    test_write_priority();
    test_early_withdraw();
    test_zero_wait();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
